ahbl_sram_slave: RTL

AHB-Lite slave fronting an internal word-organised SRAM array; the responder end of the AHB-Lite master port that the CPU wrapper drives. Decodes HSIZE/HADDR into byte lanes, commits writes at the end of the data phase, returns reads after a parameterised number of wait states, and forwards a just-written word into an immediately following read. Sits behind the system bus decoder, one instance per on-chip memory region.

---
 rtl/ahbl_sram_slave_if.sv | 24 ++
 rtl/ahbl_sram_slave.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ahbl_sram_slave_if.sv
// AHB-Lite bus bundle between a master/decoder and one ahbl_sram_slave instance.
// HREADY is the bus-level ready returned by the interconnect, so it is a master-side output.
interface ahbl_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite slave over a 2^AW x 32 byte-lane SRAM with read wait states and write-to-read
// forwarding. Define AHBL_SRAM_ERR_EN for size/alignment checks with a two-cycle ERROR response.
module ahbl_sram_slave #(
    parameter int unsigned AW          = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic              HCLK,
    input logic              HRESET,
    ahbl_sram_slave_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRdWait, StErr1, StErr2} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          pw_valid_q, pw_valid_d;
    logic [AW-1:0] pw_addr_q, pw_addr_d;
    logic [3:0]    pw_mask_q, pw_mask_d;
    logic [31:0]   hold_q, hold_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   mem_q [2**AW];

    logic          accept;
    logic          can_accept;
    logic          illegal;
    logic          hreadyout;
    logic          resp;
    logic [2:0]    size;
    logic [1:0]    lo;
    logic [AW-1:0] addr_w;
    logic [3:0]    lane_mask;
    logic [31:0]   rd_word;
    logic          unused_bits;

    assign addr_w      = bus.HADDR[AW+1:2];
    assign lo          = bus.HADDR[1:0];
    assign size        = bus.HSIZE;
    assign accept      = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    assign unused_bits = ^{bus.HADDR[31:AW+2], bus.HTRANS[0]};

`ifdef AHBL_SRAM_ERR_EN
    assign illegal = (size > 3'd2) | ((size == 3'd1) & lo[0]) | ((size == 3'd2) & (lo != 2'd0));
`else
    assign illegal = 1'b0;
`endif

    // Oversized transfers fall into the word case; halfword lanes ignore HADDR[0].
    always_comb begin
        lane_mask = 4'b1111;
        case (size)
            3'd0:    lane_mask = 4'b0001 << lo;
            3'd1:    lane_mask = lo[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    // The write committing at this edge is merged into a read of the same word.
    always_comb begin
        rd_word = mem_q[addr_w];
        if (pw_valid_q && (pw_addr_q == addr_w)) begin
            for (int i = 0; i < 4; i++) begin
                if (pw_mask_q[i]) rd_word[8*i +: 8] = bus.HWDATA[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pw_valid_d = 1'b0;
        pw_addr_d  = pw_addr_q;
        pw_mask_d  = pw_mask_q;
        hold_d     = hold_q;
        rdata_d    = rdata_q;
        hreadyout  = 1'b1;
        resp       = 1'b0;
        can_accept = 1'b0;

        case (state_q)
            StIdle: can_accept = 1'b1;
            StRdWait: begin
                hreadyout = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                    rdata_d = hold_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StErr1: begin
                hreadyout = 1'b0;
                resp      = 1'b1;
                state_d   = StErr2;
            end
            StErr2: begin
                resp       = 1'b1;
                state_d    = StIdle;
                can_accept = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (can_accept && accept) begin
            if (illegal) begin
                state_d = StErr1;
            end else if (bus.HWRITE) begin
                pw_valid_d = 1'b1;
                pw_addr_d  = addr_w;
                pw_mask_d  = lane_mask;
            end else if (WAIT_STATES == 0) begin
                rdata_d = rd_word;
            end else begin
                hold_d  = rd_word;
                state_d = StRdWait;
                cnt_d   = 4'(WAIT_STATES - 1);
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            pw_valid_q <= 1'b0;
            pw_addr_q  <= '0;
            pw_mask_q  <= 4'd0;
            hold_q     <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pw_valid_q <= pw_valid_d;
            pw_addr_q  <= pw_addr_d;
            pw_mask_q  <= pw_mask_d;
            hold_q     <= hold_d;
            rdata_q    <= rdata_d;
        end
    end

    // Array is not reset; a reset clears pw_valid_q so no stale commit happens.
    always_ff @(posedge HCLK) begin
        if (pw_valid_q) begin
            for (int i = 0; i < 4; i++) begin
                if (pw_mask_q[i]) mem_q[pw_addr_q][8*i +: 8] <= bus.HWDATA[8*i +: 8];
            end
        end
    end

    assign bus.HREADYOUT = hreadyout;
    assign bus.HRESP     = resp;
    assign bus.HRDATA    = rdata_q;
endmodule
